// File: rtl/uart_rx_core.sv
// uart_rx_core
//   Receive half of the UART slot. Brings the asynchronous rx pin into the clock
//   domain, generates the 16x oversampling tick from the divisor register and runs
//   the start/data/stop receive FSM. Each finished frame produces a one-clock write
//   strobe together with the data byte and the frame-error flag.
//
// Ports
//   clk           in   1       system clock
//   reset         in   1       asynchronous reset, active low
//   dvsr          in   DVSR_W  baud divisor, tick period = dvsr+1 clocks
//   rx            in   1       serial input, idle high, asynchronous
//   rx_done_tick  out  1       one-clock strobe, dout/frame_err valid
//   dout          out  DBIT    last received data word, held between strobes
//   frame_err     out  1       stop bit was sampled low on the last frame
//   busy          out  1       receiver is inside a frame (FSM not idle)

module uart_rx_core #(
  parameter int DBIT    = 8,   // data bits per frame (5..8)
  parameter int SB_TICK = 16,  // ticks spent in the stop bit (16/24/32)
  parameter int DVSR_W  = 11   // width of the baud divisor
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DVSR_W-1:0] dvsr,
  input  logic              rx,
  output logic              rx_done_tick,
  output logic [DBIT-1:0]   dout,
  output logic              frame_err,
  output logic              busy
);

  // s must reach SB_TICK-1 in the stop bit and 15 in a data bit.
  localparam int S_W = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [S_W-1:0] S_MID       = S_W'(7);
  localparam logic [S_W-1:0] S_LAST_DATA = S_W'(15);
  localparam logic [S_W-1:0] S_LAST_STOP = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] N_LAST      = N_W'(DBIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer. Reset to the idle level so that leaving reset can
  // never look like a start edge.
  // ---------------------------------------------------------------------------
  logic r_sync1;
  logic r_sync2;
  logic w_rx_s;

  // NOTE: clocked state uses non-blocking assignments; with blocking ones the
  // two synchronizer stages would collapse into a single flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s = r_sync2;

  // ---------------------------------------------------------------------------
  // Baud tick generator. Using >= rather than == lets a divisor write that drops
  // below the current count wrap on the next clock instead of running to 2^N.
  // ---------------------------------------------------------------------------
  logic [DVSR_W-1:0] r_cnt;
  logic              w_tick;

  assign w_tick = (r_cnt >= dvsr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + DVSR_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM. START waits half a bit (8 ticks) to land mid-bit and re-checks
  // the line to reject glitches; every later sample is a full bit (16 ticks) on.
  // ---------------------------------------------------------------------------
  state_t           r_state;
  logic [S_W-1:0]   r_s;
  logic [N_W-1:0]   r_n;
  logic [DBIT-1:0]  r_shift;
  logic [DBIT-1:0]  r_dout;
  logic             r_ferr;
  logic             r_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_shift <= '0;
      r_dout  <= '0;
      r_ferr  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          // Start edge is taken on any clock; the tick phase is irrelevant here.
          if (!w_rx_s) begin
            r_state <= START;
            r_s     <= '0;
          end
        end

        START: begin
          if (w_tick) begin
            if (r_s == S_MID) begin
              if (!w_rx_s) begin
                r_state <= DATA;
                r_s     <= '0;
                r_n     <= '0;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_s <= r_s + S_W'(1);
            end
          end
        end

        DATA: begin
          if (w_tick) begin
            if (r_s == S_LAST_DATA) begin
              r_s     <= '0;
              // LSB arrives first, so shift in from the top.
              r_shift <= {w_rx_s, r_shift[DBIT-1:1]};
              if (r_n == N_LAST) begin
                r_state <= STOP;
              end else begin
                r_n <= r_n + N_W'(1);
              end
            end else begin
              r_s <= r_s + S_W'(1);
            end
          end
        end

        STOP: begin
          if (w_tick) begin
            if (r_s == S_LAST_STOP) begin
              // A bad stop bit still delivers the word; the flag travels with it.
              r_state <= IDLE;
              r_done  <= 1'b1;
              r_dout  <= r_shift;
              r_ferr  <= ~w_rx_s;
            end else begin
              r_s <= r_s + S_W'(1);
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign rx_done_tick = r_done;
  assign dout         = r_dout;
  assign frame_err    = r_ferr;
  assign busy         = (r_state != IDLE);

endmodule
